// File: rtl/mil_stream_reader.sv
// Read side of the escaped MIL-STD-1553 word stream: strips FFA0..FFA3 prefixes and
// emits typed words on a valid/ready port. Optional counters under MIL_STREAM_STATS_EN.
module mil_stream_reader #(
   parameter int TIMEOUT = 256
`ifdef MIL_STREAM_STATS_EN
  ,parameter int CNT_W   = 16
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifo_empty,
   output logic        fifo_rd,
   input  logic [15:0] fifo_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [1:0]  out_type,
   output logic        err_timeout
`ifdef MIL_STREAM_STATS_EN
  ,output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH1 = 3'd1,
      ST_WAIT2  = 3'd2,
      ST_FETCH2 = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   // Returns {is_escape, word_type} for a first word of the stream.
   function automatic logic [2:0] esc_decode(input logic [15:0] w);
      logic [2:0] r;
      case (w)
         16'hFFA0: r = {1'b1, 2'd3};
         16'hFFA1: r = {1'b1, 2'd1};
         16'hFFA2: r = {1'b1, 2'd2};
         16'hFFA3: r = {1'b1, 2'd0};
         default:  r = {1'b0, 2'd0};
      endcase
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [15:0]      out_data_q, out_data_d;
   logic [1:0]       out_type_q, out_type_d;
   logic [1:0]       esc_type_q, esc_type_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             err_timeout_q, err_timeout_d;
   logic [2:0]       esc_s;

   // Next-state, read strobe and output-word capture.
   always_comb begin
      state_d       = state_q;
      out_data_d    = out_data_q;
      out_type_d    = out_type_q;
      esc_type_d    = esc_type_q;
      timer_d       = timer_q;
      err_timeout_d = 1'b0;
      fifo_rd       = 1'b0;
      esc_s         = esc_decode(fifo_data);
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               state_d = ST_FETCH1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH1: begin
            if (esc_s[2]) begin
               esc_type_d = esc_s[1:0];
               timer_d    = '0;
               state_d    = ST_WAIT2;
            end else begin
               out_data_d = fifo_data;
               out_type_d = 2'd0;
               state_d    = ST_OUT;
            end
         end
         ST_WAIT2: begin
            // An escape with no payload in time is dropped, not delivered.
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               state_d = ST_FETCH2;
            end else if (timer_q == TMR_LAST) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_FETCH2: begin
            out_data_d = fifo_data;
            out_type_d = esc_type_q;
            state_d    = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         out_data_q    <= 16'h0000;
         out_type_q    <= 2'd0;
         esc_type_q    <= 2'd0;
         timer_q       <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_data_q    <= out_data_d;
         out_type_q    <= out_type_d;
         esc_type_q    <= esc_type_d;
         timer_q       <= timer_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign out_valid   = (state_q == ST_OUT);
   assign out_data    = out_data_q;
   assign out_type    = out_type_q;
   assign err_timeout = err_timeout_q;

`ifdef MIL_STREAM_STATS_EN
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Delivered-word and timeout counters, wrapping.
   always_comb begin
      word_cnt_d = word_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (out_valid && out_ready) begin
         word_cnt_d = word_cnt_q + CNT_W'(1);
      end else begin
         word_cnt_d = word_cnt_q;
      end
      if (err_timeout_d) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign word_cnt = word_cnt_q;
   assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mil_stream_reader.sv
// Self-checking bench for mil_stream_reader: queue-backed FIFO model, expected-word
// scoreboard built from the escape rules, randomized stream and handshake.
module tb_mil_stream_reader;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  typ;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd;
   logic [15:0] fifo_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_type;
   logic        err_timeout;
`ifdef MIL_STREAM_STATS_EN
   logic [15:0] word_cnt;
   logic [15:0] err_cnt;
`endif

   always #5 clk = ~clk;

   mil_stream_reader #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_rd     (fifo_rd),
      .fifo_data   (fifo_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_type    (out_type),
      .err_timeout (err_timeout)
`ifdef MIL_STREAM_STATS_EN
     ,.word_cnt    (word_cnt),
      .err_cnt     (err_cnt)
`endif
   );

   logic [15:0] fifo_q[$];
   word_t       exp_q[$];
   int vectors = 0, errors = 0;
   int cycle = 0, rd_cnt = 0, to_cnt = 0, valid_cnt = 0;
   int first_rd = -1, first_valid = -1, to_cycle = -1;
   logic        hold_vld = 1'b0;
   logic [15:0] hold_data = 16'h0000;
   logic [1:0]  hold_type = 2'd0;

   // Escape prefix that announces a word of the given type.
   function automatic logic [15:0] prefix_for(input int t);
      case (t)
         0:       return 16'hFFA3;
         1:       return 16'hFFA1;
         2:       return 16'hFFA2;
         default: return 16'hFFA0;
      endcase
   endfunction

   task automatic push_word(input logic [15:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic expect_word(input logic [15:0] d, input logic [1:0] t);
      word_t e;
      e.data = d;
      e.typ  = t;
      exp_q.push_back(e);
   endtask

   task automatic mark();
      rd_cnt = 0; to_cnt = 0; valid_cnt = 0;
      first_rd = -1; first_valid = -1; to_cycle = -1;
   endtask

   // One clock: observe at the falling edge, then serve the FIFO read after the rising edge.
   task automatic cyc();
      logic  rd;
      word_t e;
      @(negedge clk);
      cycle++;
      rd = fifo_rd;
      if (rd) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cycle;
      end
      if (out_valid) begin
         valid_cnt++;
         if (first_valid < 0) first_valid = cycle;
      end
      if (err_timeout) begin
         to_cnt++;
         to_cycle = cycle;
      end
      if (hold_vld) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== hold_data || out_type !== hold_type) begin
            errors++;
            $display("FAIL hold_stable: got v=%b %h/%0d expected v=1 %h/%0d",
                     out_valid, out_data, out_type, hold_data, hold_type);
         end
      end
      if (out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h/%0d expected no word", out_data, out_type);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_type !== e.typ) begin
               errors++;
               $display("FAIL word: got %h/%0d expected %h/%0d", out_data, out_type, e.data, e.typ);
            end
         end
         hold_vld = 1'b0;
      end else begin
         hold_vld  = out_valid;
         hold_data = out_data;
         hold_type = out_type;
      end
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      out_ready = 1'b1;
      while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < budget) begin
         cyc();
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
         exp_q.delete();
      end
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; fifo_empty = 1'b1; fifo_data = 16'h0000; out_ready = 1'b0;
      repeat (3) cyc();
      vectors++;
      if ({fifo_rd, out_valid, out_data, out_type, err_timeout} !== 21'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b v=%b %h/%0d to=%b expected all 0",
                  fifo_rd, out_valid, out_data, out_type, err_timeout);
      end
`ifdef MIL_STREAM_STATS_EN
      vectors++;
      if (word_cnt !== 16'd0 || err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", word_cnt, err_cnt);
      end
`endif
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_plain();
      mark();
      out_ready = 1'b1;
      push_word(16'h1234);
      expect_word(16'h1234, 2'd0);
      drain(20);
      vectors++;
      if (first_valid - first_rd != 2) begin
         errors++;
         $display("FAIL plain_latency: got %0d expected 2", first_valid - first_rd);
      end
      vectors++;
      if (rd_cnt != 1) begin
         errors++;
         $display("FAIL plain_reads: got %0d expected 1", rd_cnt);
      end
   endtask

   task automatic test_escape();
      mark();
      push_word(16'hFFA1);
      push_word(16'h0C21);
      expect_word(16'h0C21, 2'd1);
      drain(20);
      vectors++;
      if (first_valid - first_rd != 4) begin
         errors++;
         $display("FAIL escape_latency: got %0d expected 4", first_valid - first_rd);
      end
      vectors++;
      if (rd_cnt != 2) begin
         errors++;
         $display("FAIL escape_reads: got %0d expected 2", rd_cnt);
      end
   endtask

   task automatic test_verbatim();
      mark();
      push_word(16'hFFA3);
      push_word(16'hFFA2);
      expect_word(16'hFFA2, 2'd0);
      drain(20);
      vectors++;
      if (rd_cnt != 2 || valid_cnt != 1) begin
         errors++;
         $display("FAIL verbatim_count: got rd=%0d valid=%0d expected rd=2 valid=1", rd_cnt, valid_cnt);
      end
   endtask

   task automatic test_timeout();
      mark();
      out_ready = 1'b1;
      push_word(16'hFFA2);
      repeat (14) cyc();
      vectors++;
      if (to_cnt != 1 || to_cycle - first_rd != TIMEOUT + 2) begin
         errors++;
         $display("FAIL timeout_pulse: got cnt=%0d delay=%0d expected cnt=1 delay=%0d",
                  to_cnt, to_cycle - first_rd, TIMEOUT + 2);
      end
      vectors++;
      if (valid_cnt != 0) begin
         errors++;
         $display("FAIL timeout_no_word: got %0d valid cycles expected 0", valid_cnt);
      end
      push_word(16'h0055);
      expect_word(16'h0055, 2'd0);
      drain(20);
   endtask

   task automatic test_backpressure();
      int n = 0;
      mark();
      out_ready = 1'b0;
      push_word(16'hABCD);
      push_word(16'h5678);
      expect_word(16'hABCD, 2'd0);
      expect_word(16'h5678, 2'd0);
      while (first_valid < 0 && n < 10) begin
         cyc();
         n++;
      end
      repeat (10) cyc();
      vectors++;
      if (rd_cnt != 1 || valid_cnt != 11) begin
         errors++;
         $display("FAIL backpressure: got rd=%0d valid=%0d expected rd=1 valid=11", rd_cnt, valid_cnt);
      end
      drain(30);
      vectors++;
      if (rd_cnt != 2) begin
         errors++;
         $display("FAIL backpressure_reads: got %0d expected 2", rd_cnt);
      end
   endtask

   task automatic test_random();
      logic [15:0] w;
      int          t;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 4) begin
            t = int'($urandom_range(0, 3));
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w = 16'hFFA0 + 16'($urandom_range(0, 3));
            push_word(prefix_for(t));
            push_word(w);
            expect_word(w, 2'(t));
         end else begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w = 16'hFFA0 + 16'($urandom_range(4, 15));
            while (w >= 16'hFFA0 && w <= 16'hFFA3) w = 16'($urandom);
            push_word(w);
            expect_word(w, 2'd0);
         end
         for (int g = 0; g <= int'($urandom_range(0, 3)); g++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
         end
      end
      drain(600);
   endtask

   task automatic test_reset_wait2();
      mark();
      push_word(16'hFFA0);
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      vectors++;
      if ({fifo_rd, out_valid, out_data, out_type, err_timeout} !== 21'h0) begin
         errors++;
         $display("FAIL reset_wait2: got rd=%b v=%b %h/%0d to=%b expected all 0",
                  fifo_rd, out_valid, out_data, out_type, err_timeout);
      end
`ifdef MIL_STREAM_STATS_EN
      vectors++;
      if (word_cnt !== 16'd0 || err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_wait2_counters: got %0d/%0d expected 0/0", word_cnt, err_cnt);
      end
`endif
      rst = 1'b0;
      repeat (12) cyc();
      vectors++;
      if (to_cnt != 0 || valid_cnt != 0) begin
         errors++;
         $display("FAIL reset_drops_escape: got to=%0d valid=%0d expected 0/0", to_cnt, valid_cnt);
      end
   endtask

   task automatic test_stats();
      mark();
      for (int i = 0; i < 5; i++) begin
         push_word(16'h0100 + 16'(i));
         expect_word(16'h0100 + 16'(i), 2'd0);
      end
      drain(40);
      push_word(16'hFFA1);
      repeat (14) cyc();
      vectors++;
      if (to_cnt != 1) begin
         errors++;
         $display("FAIL stats_timeout: got %0d expected 1", to_cnt);
      end
`ifdef MIL_STREAM_STATS_EN
      vectors++;
      if (word_cnt !== 16'd5 || err_cnt !== 16'd1) begin
         errors++;
         $display("FAIL stats_counters: got %0d/%0d expected 5/1", word_cnt, err_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_plain();
      test_escape();
      test_verbatim();
      test_timeout();
      test_backpressure();
      test_random();
      test_reset_wait2();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
